// File: rtl/q_mul_arbiter.sv
// q_mul_arbiter: shares one fixed-point q_mul among N_REQ requesters.
// Round-robin grant, valid/ready handshakes on both sides, and a two-stage
// registered pipeline (operand stage, output stage) that tags every product
// with the index of the requester that issued it.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif

// Signed fixed-point multiply: full-precision product rescaled by the
// fractional bit count, then truncated back to the operand width.
module q_mul #(
  parameter int W    = `FIXED_WIDTH,
  parameter int FRAC = $clog2(`SCALE_FACTOR)
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);
  logic signed [2*W-1:0] full_s;

  assign full_s = a * b;
  assign p      = W'(full_s >>> FRAC);
endmodule

module q_mul_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*`FIXED_WIDTH-1:0]    req_a,
  input  logic [N_REQ*`FIXED_WIDTH-1:0]    req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic signed [`FIXED_WIDTH-1:0]   rsp_data,
  output logic [ID_W-1:0]                  rsp_id
);
  localparam int FW = `FIXED_WIDTH;

  // operand stage
  logic                  op_valid_r;
  logic signed [FW-1:0]  op_a_r;
  logic signed [FW-1:0]  op_b_r;
  logic [ID_W-1:0]       op_id_r;
  // output stage
  logic                  rsp_valid_r;
  logic signed [FW-1:0]  rsp_data_r;
  logic [ID_W-1:0]       rsp_id_r;
  // round-robin pointer: index of the most recent grant
  logic [ID_W-1:0]       last_grant_r;

  logic                  grant_found_s;
  logic [ID_W-1:0]       grant_idx_s;
  logic                  advance_s;
  logic                  accept_s;
  logic signed [FW-1:0]  sel_a_s;
  logic signed [FW-1:0]  sel_b_s;
  logic signed [FW-1:0]  mul_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int cand_v;
    grant_found_s = 1'b0;
    grant_idx_s   = last_grant_r;
    cand_v        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_v = int'(last_grant_r) + k;
      if (cand_v >= N_REQ) begin
        cand_v = cand_v - N_REQ;
      end else begin
        cand_v = cand_v;
      end
      if (!grant_found_s && req_valid[cand_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ID_W'(cand_v);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Handshake qualifiers; reset gates accept so no requester sees ready
  // while the pipeline is being cleared.
  assign advance_s = op_valid_r && (!rsp_valid_r || rsp_ready);
  assign accept_s  = !rst && (!op_valid_r || advance_s) && grant_found_s;

  // One-hot ready toward the granted requester only when a transfer happens.
  always_comb begin
    if (accept_s) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  assign sel_a_s = req_a[grant_idx_s*FW +: FW];
  assign sel_b_s = req_b[grant_idx_s*FW +: FW];

  q_mul #(.W(FW)) u_q_mul (
    .a (op_a_r),
    .b (op_b_r),
    .p (mul_s)
  );

  // Output stage: load on advance, drain when the consumer takes the last product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {FW{1'b0}};
      rsp_id_r    <= {ID_W{1'b0}};
    end else if (advance_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= mul_s;
      rsp_id_r    <= op_id_r;
    end else if (rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Operand stage and pointer: capture the granted operands, empty on a bare advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_r   <= 1'b0;
      op_a_r       <= {FW{1'b0}};
      op_b_r       <= {FW{1'b0}};
      op_id_r      <= {ID_W{1'b0}};
      last_grant_r <= ID_W'(N_REQ - 1);
    end else if (accept_s) begin
      op_valid_r   <= 1'b1;
      op_a_r       <= sel_a_s;
      op_b_r       <= sel_b_s;
      op_id_r      <= grant_idx_s;
      last_grant_r <= grant_idx_s;
    end else if (advance_s) begin
      op_valid_r   <= 1'b0;
    end else begin
      op_valid_r   <= op_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
endmodule

// File: tb/tb_q_mul_arbiter.sv
// Directed bench for q_mul_arbiter: inputs change just after the falling
// edge, outputs are checked 1 ns later, well away from the rising edge.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 256
`endif

module tb_q_mul_arbiter;
  localparam int N  = 4;
  localparam int FW = `FIXED_WIDTH;
  localparam int SF = `SCALE_FACTOR;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N*FW-1:0]        req_a;
  logic [N*FW-1:0]        req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic signed [FW-1:0]   rsp_data;
  logic [1:0]             rsp_id;

  logic signed [FW-1:0]   a_arr [N];
  logic signed [FW-1:0]   b_arr [N];

  int n_cmp = 0;
  int n_bad = 0;

  q_mul_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // free-running clock
  always #5 clk = ~clk;

  // pack per-requester operands into the flat buses
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*FW +: FW] = a_arr[i];
      req_b[i*FW +: FW] = b_arr[i];
    end
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int id, input int data);
    check_eq({tag, ".valid"}, 32'(rsp_valid), 32'(1));
    check_eq({tag, ".id"},    32'(rsp_id),    32'(id));
    check_eq({tag, ".data"},  32'(rsp_data),  32'(data));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 16'sd0;
      b_arr[i] = 16'sd0;
    end

    // ---- reset state ----
    #1;
    check_eq("rst.rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("rst.req_ready", 32'(req_ready), 32'(0));
    check_eq("rst.rsp_data",  32'(rsp_data),  32'(0));
    check_eq("rst.rsp_id",    32'(rsp_id),    32'(0));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // ---- single request on requester 2: SF/2 * SF/4 ----
    a_arr[2] = FW'(SF/2); b_arr[2] = FW'(SF/4);
    req_valid = 4'b0100;
    #1 check_eq("single.ready", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = 4'b0000;
    #1 check_eq("single.lat1", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    #1 chk_rsp("single", 2, SF/8);
    @(negedge clk);
    #1 check_eq("single.drain", 32'(rsp_valid), 32'(0));

    // ---- sign handling: req1 SF*-SF, req3 -SF/2*-SF/4 ----
    a_arr[1] = FW'(SF);    b_arr[1] = FW'(-SF);
    a_arr[3] = FW'(-SF/2); b_arr[3] = FW'(-SF/4);
    req_valid = 4'b0010;
    #1 check_eq("sign.ready1", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = 4'b1000;
    #1 check_eq("sign.ready3", 32'(req_ready), 32'(4'b1000));
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk_rsp("sign1", 1, -SF);
    @(negedge clk);
    #1 chk_rsp("sign3", 3, SF/8);

    // ---- pointer hold: last grant 3, then 0 alone, then 1 and 3 ----
    @(negedge clk);
    req_valid = 4'b0001;
    #1 check_eq("ptr.ready0", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = 4'b1010;
    #1 check_eq("ptr.ready1", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // ---- round robin after reset, all four requesting ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = FW'((i + 1) * SF);
      b_arr[i] = FW'(SF/2);
    end
    for (int j = 0; j < 10; j++) begin
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (j < 8) check_eq($sformatf("rr.ready%0d", j), 32'(req_ready), 32'(1 << (j % 4)));
      if (j >= 2) chk_rsp($sformatf("rr%0d", j), (j - 2) % 4, (((j - 2) % 4) + 1) * (SF/2));
      @(negedge clk);
    end

    // ---- backpressure: two requests while rsp_ready=0 ----
    rsp_ready = 1'b0;
    a_arr[0] = FW'(SF);   b_arr[0] = FW'(3*SF);
    a_arr[1] = FW'(2*SF); b_arr[1] = FW'(-SF/2);
    a_arr[2] = FW'(SF);   b_arr[2] = FW'(SF);
    req_valid = 4'b0001;
    #1 check_eq("bp.ready0", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = 4'b0010;
    #1 check_eq("bp.ready1", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk_rsp($sformatf("bp.hold%0d", j), 0, 3*SF);
      check_eq($sformatf("bp.noready%0d", j), 32'(req_ready), 32'(0));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1 chk_rsp("bp.first", 0, 3*SF);
    @(negedge clk);
    #1 chk_rsp("bp.second", 1, -SF);
    @(negedge clk);
    #1 check_eq("bp.drain", 32'(rsp_valid), 32'(0));

    // ---- reset mid-stream with both stages full ----
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1 check_eq("mid.ready2", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = 4'b0010;
    #1 check_eq("mid.ready1", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    check_eq("mid.full", 32'(rsp_valid), 32'(1));
    check_eq("mid.stall", 32'(req_ready), 32'(0));
    #1 rst = 1'b1;
    #1;
    check_eq("mid.rst_valid", 32'(rsp_valid), 32'(0));
    check_eq("mid.rst_ready", 32'(req_ready), 32'(0));
    check_eq("mid.rst_id",    32'(rsp_id),    32'(0));
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    a_arr[0] = FW'(SF/4); b_arr[0] = FW'(-SF);
    #1 check_eq("mid.first_grant", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = 4'b0000;
    #1 check_eq("mid.no_stale", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    #1 chk_rsp("mid.rsp", 0, -SF/4);
    @(negedge clk);
    #1 check_eq("mid.drain", 32'(rsp_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/q_mul_arbiter.md
Name: q_mul_arbiter

Overview:
- Shares one `q_mul` fixed-point multiplier instance among N_REQ requesters.
- Round-robin arbitration, valid/ready handshakes and a two-stage registered pipeline with response tagging.
- Sits between multiple datapath clients (filters, MAC sequencers) and a single multiplier resource; sustains one product per cycle.
- Operand/result format is `FIXED_WIDTH` signed, scaled by `SCALE_FACTOR`, both from `include.vh`.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of the response tag; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  N_REQ*FIXED_WIDTH  packed operand a; requester i occupies bits [i*FIXED_WIDTH +: FIXED_WIDTH].
- req_b  input  N_REQ*FIXED_WIDTH  packed operand b; same packing as req_a.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accepts the product.
- rsp_data  output  FIXED_WIDTH  signed product, exactly as `q_mul` computes it.
- rsp_id  output  ID_W  index of the requester that issued the product.

Behaviour:
- Pipeline registers:
  - Stage 1 (operand): op_valid, op_a, op_b, op_id.
  - Stage 2 (output): rsp_valid, rsp_data, rsp_id.
  - `q_mul` is combinational, between op_a/op_b and the stage-2 data input.
- Reset (async assert, takes effect immediately):
  - op_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
  - Priority pointer last_grant=N_REQ-1, so requester 0 has highest priority first.
- advance = op_valid && (!rsp_valid || rsp_ready). On advance, stage 2 loads q_mul(op_a,op_b) and op_id, and rsp_valid=1.
- If rsp_valid && rsp_ready && !op_valid, rsp_valid clears on that edge.
- accept = (!op_valid || advance) && |req_valid.
- req_ready is combinational:
  - Only the granted requester's bit is 1, and only when accept is true.
  - req_ready never depends on that requester's own req_valid beyond arbitration.
- Grant (round robin):
  - Search order is last_grant+1, last_grant+2, ... modulo N_REQ; the first asserted req_valid wins.
  - On accept, stage 1 loads that requester's a/b, op_id=index, op_valid=1, last_grant=index.
  - When there is no accept, last_grant is unchanged.
- Stage 1 keeps its contents when it is not advancing. op_valid clears when advance && !accept.
- Latency: handshake at edge k gives rsp_valid=1 after edge k+1, i.e. two cycles from request to visible product.
- Throughput: one per cycle while rsp_ready=1.
- Backpressure:
  - While rsp_valid && !rsp_ready, stage 2 holds rsp_data/rsp_id stable.
  - Stage 1 can still fill once; after that all req_ready are 0.
- No product is ever dropped or duplicated; each handshake yields exactly one response with the matching id.
- Requester protocol:
  - A requester holding req_valid must keep its a/b stable until its req_ready.
  - The arbiter does not check this.
- Simultaneous events: rsp handshake, stage-1 advance and new accept may all occur on the same edge (full-rate streaming).
- Fairness: with all N_REQ requesting continuously and rsp_ready=1, grants cycle 0,1,...,N_REQ-1,0,...
- Reset mid-operation: in-flight operands and products are discarded, with no response issued for them.

Test Plan:
- Single request, SCALE_FACTOR/2 × SCALE_FACTOR/4 on requester 2, rsp_ready=1:
  - req_ready[2] asserts in the same cycle.
  - Two cycles later rsp_valid=1, rsp_data=SCALE_FACTOR/8, rsp_id=2.
- Sign handling:
  - Requester 1: SCALE_FACTOR × −SCALE_FACTOR → rsp_data=−SCALE_FACTOR, rsp_id=1.
  - Requester 3: −SCALE_FACTOR/2 × −SCALE_FACTOR/4 → rsp_data=SCALE_FACTOR/8.
- Round robin:
  - All 4 requesters valid continuously, rsp_ready=1, after reset.
  - rsp_id sequence is 0,1,2,3,0,1,2,3 on consecutive cycles with correct products.
- Backpressure:
  - rsp_ready=0 for 5 cycles with 2 requests issued.
  - rsp_data/rsp_id stay frozen, stage 1 holds the second request, all req_ready=0.
  - After rsp_ready=1, both responses appear in order on back-to-back cycles.
- Pointer hold: requester 3 granted, then only requester 0 requests → 0 is granted. Then 1 and 3 request together → 1 wins.
- Reset mid-stream:
  - Assert rst asynchronously with both stages full.
  - rsp_valid and req_ready drop immediately.
  - After release, the first grant goes to requester 0.
